spi_sample_rx: RTL
==================

Name: spi_sample_rx

Overview:
- FPGA-side SPI peripheral that receives raw audio samples from the MCU, which acts as SPI controller.
- Receive-direction counterpart of the datapath's outbound SPI path to the MCU.
- Synchronizes sclk/cs_n/sdi into clk, assembles MSB-first words, and buffers them in a small FIFO.
- Presents samples to the effects datapath with a valid/ready handshake and pulses start on each accepted word.

Parameters:
- DATA_W, 16, sample width in bits; also the exact number of bits in a valid frame.
- DEPTH, 4, FIFO depth in words; power of two, at least 2.

Ports:
- clk  input  1  system clock; must be at least 8x sclk.
- reset  input  1  reset, asynchronous, active-high.
- sclk  input  1  SPI clock from MCU; asynchronous; mode 0.
- cs_n  input  1  SPI chip select from MCU; asynchronous; active-low.
- sdi  input  1  SPI data from MCU; asynchronous.
- sample_data  output  DATA_W  FIFO head word.
- sample_valid  output  1  FIFO non-empty.
- sample_ready  input  1  datapath consumes head when high together with sample_valid.
- start  output  1  one-cycle pulse on every FIFO push.
- overflow  output  1  sticky: a good word was dropped because the FIFO was full.
- frame_err  output  1  sticky: a frame was discarded for bad length.
- clr_flags  input  1  synchronous clear of overflow and frame_err.

Behaviour:
- Reset values: sample_data 0, sample_valid 0, start 0, overflow 0, frame_err 0; FIFO empty; FSM in IDLE.
- Synchronization:
  - sclk, cs_n and sdi each pass through a 2-FF synchronizer, then one history register for edge detection.
  - The sclk rising edge is detected 3 clk cycles after the pin edge.
  - sdi is sampled from the same synchronizer stage as sclk, so data and clock stay aligned.
- FSM states and transitions:
  - IDLE: waits for a falling edge of synced cs_n, then clears the shift register and bit counter and goes to SHIFT. A cs_n already low when leaving reset is ignored until it rises and falls again.
  - SHIFT: on each detected sclk rise, shift = {shift[DATA_W-2:0], sdi}; bit count increments, saturating at DATA_W+1. A detected cs_n rise moves to CHECK.
  - CHECK: lasts 1 cycle.
    - If bit count == DATA_W, attempt a push.
    - Otherwise set frame_err and discard the word.
    - Always return to IDLE.
- Push rules:
  - If the FIFO is not full, or a pop happens in the same cycle, the word is written and start pulses high for exactly that cycle.
  - If the FIFO is full and no pop happens, the word is dropped, overflow is set and start stays 0.
- sample_valid rises the cycle after the push edge. End-to-end latency from the cs_n pin rising edge to sample_valid is 5 clk cycles.
- Pop:
  - A pop occurs when sample_valid && sample_ready.
  - The head advances on that edge, and sample_data shows the next word the following cycle.
  - sample_ready while empty has no effect.
- FIFO structure:
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits.
  - Full means count == DEPTH; empty means count == 0.
  - Simultaneous push and pop leaves count unchanged, including when the FIFO is full or empty.
- sample_data is the registered FIFO head. Its value is don't-care while sample_valid is 0, but it must hold stable while sample_valid && !sample_ready.
- Flags:
  - clr_flags clears overflow and frame_err on the next edge.
  - If a set event and clr_flags occur in the same cycle, the set wins.
- Reset mid-frame discards the partial word and all FIFO contents; no start pulse is produced.

Optional Feature:
- SPI_RX_ERR_CNT_EN defined:
  - Adds output err_count, 8 bits, reset to 0.
  - Increments on every frame_err or overflow event and saturates at 255.
  - Cleared by clr_flags, with the same priority rule as the flags (an event in the same cycle wins).
- SPI_RX_ERR_CNT_EN undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Single frame 0xA5C3 with sclk = clk/10 and sample_ready=0:
  - start pulses once.
  - sample_valid=1 and sample_data=0xA5C3 exactly 5 clk cycles after cs_n rises.
  - Data holds until sample_ready=1, then sample_valid drops the next cycle.
- Five back-to-back frames 0x0001..0x0005 with sample_ready=0 and DEPTH=4:
  - Four start pulses; overflow=1.
  - Draining yields 0x0001..0x0004 in order; 0x0005 is lost.
- FIFO full, sample_ready held at 1 across the CHECK cycle of a new frame 0x1234:
  - Pop and push happen in the same cycle; overflow stays 0; count stays 4.
  - 0x1234 appears as the last drained word.
- Frame of 15 bits, then a frame of 17 bits:
  - frame_err=1, no start pulses, FIFO empty.
  - clr_flags pulse, then a valid 16-bit frame 0xBEEF: frame_err=0 and 0xBEEF is delivered.
- reset asserted after 8 bits of a frame, then deasserted while cs_n is still low:
  - That frame's remaining bits are ignored; no start pulse, sample_valid=0.
  - The next full frame 0x7FFF is received correctly.
- With SPI_RX_ERR_CNT_EN defined: 300 consecutive bad-length frames give err_count=255; clr_flags returns it to 0.

Source files
------------

// File: rtl/spi_sample_rx.sv
// -----------------------------------------------------------------------------
// spi_sample_rx
//
// Purpose:
//   SPI peripheral (mode 0, MCU is the controller) that receives raw audio
//   samples. The SPI pins are synchronized into clk, and each frame is
//   assembled MSB-first. A frame is accepted only if it holds exactly DATA_W
//   bits. Accepted words are buffered in a small FIFO and handed to the
//   effects datapath with a valid/ready handshake.
//
// Ports:
//   clk           system clock (at least 8x sclk)
//   reset         asynchronous, active-high reset
//   sclk, cs_n,   SPI pins from the MCU. These are asynchronous to clk.
//   sdi
//   sample_data   registered FIFO head word
//   sample_valid  FIFO head is valid
//   sample_ready  datapath consumes the head when sample_valid is also high
//   start         one-cycle pulse for every word written into the FIFO
//   overflow      sticky: a good word was dropped because the FIFO was full
//   frame_err     sticky: a frame of the wrong length was discarded
//   clr_flags     synchronous clear of the sticky flags (a set event wins)
//   err_count     (only when SPI_RX_ERR_CNT_EN is defined) saturating 8-bit
//                 count of frame_err and overflow events
//
// Optional build macro: SPI_RX_ERR_CNT_EN
// -----------------------------------------------------------------------------
module spi_sample_rx #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              sdi,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              start,
    output logic              overflow,
    output logic              frame_err,
    input  logic              clr_flags
`ifdef SPI_RX_ERR_CNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BC_W  = $clog2(DATA_W + 2);

    localparam logic [BC_W-1:0]  BC_FULL = BC_W'(DATA_W);
    localparam logic [BC_W-1:0]  BC_MAX  = BC_W'(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // Pin synchronizers: index 0 = sclk, 1 = cs_n, 2 = sdi.
    // All stages reset to 0. For cs_n this means "selected". If cs_n is
    // already low when reset is released, no falling edge is seen. The
    // frame in flight is therefore ignored until cs_n rises and falls again.
    // ------------------------------------------------------------------
    logic [2:0] pin_w;
    logic [2:0] sync_w;
    assign pin_w = {sdi, cs_n, sclk};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic s1_q;
            logic s2_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1_q <= 1'b0;
                    s2_q <= 1'b0;
                end else begin
                    s1_q <= pin_w[gi];
                    s2_q <= s1_q;
                end
            end
            assign sync_w[gi] = s2_q;
        end
    endgenerate

    logic sclk_s, cs_s, sdi_s;
    assign sclk_s = sync_w[0];
    assign cs_s   = sync_w[1];
    assign sdi_s  = sync_w[2];

    // History stage for edge detection. It is only needed for sclk and cs_n.
    // sdi is taken from the same stage as sclk, so the two stay aligned.
    logic sclk_h_q, cs_h_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_h_q <= 1'b0;
            cs_h_q   <= 1'b0;
        end else begin
            sclk_h_q <= sclk_s;
            cs_h_q   <= cs_s;
        end
    end

    logic sclk_rise, cs_fall, cs_rise;
    assign sclk_rise = sclk_s & ~sclk_h_q;
    assign cs_fall   = ~cs_s & cs_h_q;
    assign cs_rise   = cs_s & ~cs_h_q;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic              push_req;
    logic              len_err;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        push_req  = 1'b0;
        len_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    shift_d = {shift_q[DATA_W-2:0], sdi_s};
                    // The count saturates one past DATA_W, so that any
                    // over-long frame is still seen as the wrong length.
                    if (bit_cnt_q != BC_MAX) begin
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                    end
                end
                if (cs_rise) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (bit_cnt_q == BC_FULL) begin
                    push_req = 1'b1;
                end else begin
                    len_err = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  avail_w;
    logic              sample_valid_q, sample_valid_d;
    logic [DATA_W-1:0] sample_data_q;
    logic              full_w, pop_w, push_w, ovf_set;

    assign full_w  = (count_q == CNT_MAX);
    assign pop_w   = sample_valid_q & sample_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push_w  = push_req & (~full_w | pop_w);
    assign ovf_set = push_req & full_w & ~pop_w;

    assign wr_ptr_d = wr_ptr_q + PTR_W'(push_w);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(pop_w);
    assign count_d  = count_q + CNT_W'(push_w) - CNT_W'(pop_w);

    // The output register only considers words stored before this edge.
    // This keeps the read address away from the word being written now.
    // A fresh push therefore appears one cycle after its write edge.
    assign avail_w        = count_q - CNT_W'(pop_w);
    assign sample_valid_d = (avail_w != '0);

    always_ff @(posedge clk) begin
        if (push_w) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            sample_valid_q <= 1'b0;
            sample_data_q  <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            sample_valid_q <= sample_valid_d;
            // Registered read at the next head address. If there is no pop,
            // the same word is reread, so the head stays stable while stalled.
            sample_data_q  <= mem_q[rd_ptr_d];
        end
    end

    // ------------------------------------------------------------------
    // Start pulse and sticky flags (a set event beats clr_flags)
    // ------------------------------------------------------------------
    logic start_q, overflow_q, overflow_d, frame_err_q, frame_err_d;

    always_comb begin
        overflow_d  = overflow_q;
        frame_err_d = frame_err_q;
        if (clr_flags) begin
            overflow_d  = 1'b0;
            frame_err_d = 1'b0;
        end
        if (ovf_set) begin
            overflow_d = 1'b1;
        end
        if (len_err) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q     <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            start_q     <= push_w;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef SPI_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (ovf_set | len_err) begin
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end else if (clr_flags) begin
            err_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`endif

    assign sample_data  = sample_data_q;
    assign sample_valid = sample_valid_q;
    assign start        = start_q;
    assign overflow     = overflow_q;
    assign frame_err    = frame_err_q;

endmodule
